// File: rtl/shake_pkg.sv
// Shared SHAKE constants and the byte-enable helper.
// Used by the output buffer and its interface.
package shake_pkg;

  localparam int SHAKE128_RATE_W = 1344;
  localparam int SHAKE256_RATE_W = 1088;
  localparam int SHAKE_DATA_W = 64;
  localparam int SHAKE128_RATE_WORDS = 21;
  localparam int SHAKE256_RATE_WORDS = 17;

  localparam int KEEP_MAX = 128;

  function automatic logic [KEEP_MAX-1:0] keep_mask(
    input int unsigned bytes
  );
    logic [KEEP_MAX-1:0] m;
    m = '0;
    for (int i = 0; i < KEEP_MAX; i++) begin
      m[i] = (i < bytes);
    end
    return m;
  endfunction

endpackage

// File: rtl/shake_output_buffer_if.sv
// Control/data bundle between the dump FSM and the output buffer.
// master: FSM side; slave: buffer side.
interface shake_output_buffer_if
  import shake_pkg::*;
#(
  parameter int RATE_W = SHAKE128_RATE_W,
  parameter int DATA_W = SHAKE_DATA_W
);
  localparam int WORDS = RATE_W / DATA_W;
  localparam int CNT_W = $clog2(WORDS + 1);
  localparam int BYTES_W = $clog2(DATA_W / 8 + 1);
  localparam int KEEP_W = DATA_W / 8;

  logic [RATE_W-1:0]  state_in;
  logic [CNT_W-1:0]   rate_words_in;
  logic [CNT_W-1:0]   last_words_in;
  logic [BYTES_W-1:0] last_bytes_in;
  logic               output_buffer_we;
  logic               last_output_block;
  logic               output_counter_load;
  logic               output_counter_rst;
  logic               output_buffer_shift_en;
  logic               valid_bytes_enable;
  logic               valid_bytes_reset;
  logic               output_buffer_empty;
  logic [DATA_W-1:0]  data_out;
  logic [KEEP_W-1:0]  keep_out;
  logic               last_out;

  modport master (
    output state_in,
    output rate_words_in,
    output last_words_in,
    output last_bytes_in,
    output output_buffer_we,
    output last_output_block,
    output output_counter_load,
    output output_counter_rst,
    output output_buffer_shift_en,
    output valid_bytes_enable,
    output valid_bytes_reset,
    input  output_buffer_empty,
    input  data_out,
    input  keep_out,
    input  last_out
  );

  modport slave (
    input  state_in,
    input  rate_words_in,
    input  last_words_in,
    input  last_bytes_in,
    input  output_buffer_we,
    input  last_output_block,
    input  output_counter_load,
    input  output_counter_rst,
    input  output_buffer_shift_en,
    input  valid_bytes_enable,
    input  valid_bytes_reset,
    output output_buffer_empty,
    output data_out,
    output keep_out,
    output last_out
  );

endinterface

// File: rtl/shake_output_buffer.sv
// Holds the squeezed rate slice and drains it word by word,
// lane 0 first, with word counter, final byte mask and last flag.
module shake_output_buffer
  import shake_pkg::*;
#(
  parameter int RATE_W = SHAKE128_RATE_W,
  parameter int DATA_W = SHAKE_DATA_W
) (
  input logic clk,
  input logic rst,
  shake_output_buffer_if.slave bus
);

  localparam int WORDS = RATE_W / DATA_W;
  localparam int CNT_W = $clog2(WORDS + 1);
  localparam int BYTES_W = $clog2(DATA_W / 8 + 1);
  localparam int KEEP_W = DATA_W / 8;

  localparam logic [CNT_W-1:0] WORDS_C = CNT_W'(WORDS);
  localparam logic [BYTES_W-1:0] FULL_B = BYTES_W'(KEEP_W);

  logic [RATE_W-1:0]   r_buf;
  logic [CNT_W-1:0]    r_cnt;
  logic [BYTES_W-1:0]  r_bytes;
  logic                r_last;

  logic                w_nz;
  logic                w_shift;
  logic [CNT_W-1:0]    w_pick;
  logic [CNT_W-1:0]    w_load_val;
  logic                w_bytes_ok;
  logic                w_last;
  logic [KEEP_MAX-1:0] w_mask;

  assign w_nz = (r_cnt != '0);
  assign w_shift = bus.output_buffer_shift_en && w_nz;

  // A zero final-block length falls back to the full rate.
  always_comb begin
    w_pick = bus.rate_words_in;
    if (bus.last_output_block && (bus.last_words_in != '0)) begin
      w_pick = bus.last_words_in;
    end
    w_load_val = (w_pick > WORDS_C) ? WORDS_C : w_pick;
  end

  assign w_bytes_ok = (bus.last_bytes_in != '0) &&
                      (bus.last_bytes_in <= FULL_B);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf <= '0;
    end else if (bus.output_buffer_we) begin
      r_buf <= bus.state_in;
    end else if (w_shift) begin
      r_buf <= r_buf >> DATA_W;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (bus.output_counter_rst) begin
      r_cnt <= '0;
    end else if (bus.output_counter_load) begin
      r_cnt <= w_load_val;
    end else if (w_shift) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bytes <= FULL_B;
      r_last  <= 1'b0;
    end else if (bus.valid_bytes_reset) begin
      r_bytes <= FULL_B;
      r_last  <= 1'b0;
    end else if (bus.valid_bytes_enable) begin
      r_bytes <= w_bytes_ok ? bus.last_bytes_in : FULL_B;
      r_last  <= 1'b1;
    end
  end

  assign w_last = r_last && (r_cnt == CNT_W'(1));
  assign w_mask = keep_mask(32'(r_bytes));

  assign bus.data_out = r_buf[DATA_W-1:0];
  assign bus.output_buffer_empty = !w_nz;
  assign bus.last_out = w_last;
  assign bus.keep_out = w_last ? w_mask[KEEP_W-1:0] : '1;

  generate
    if (KEEP_W < KEEP_MAX) begin : g_mask_hi
      logic w_unused_mask;
      assign w_unused_mask = ^w_mask[KEEP_MAX-1:KEEP_W];
    end
  endgenerate

`ifndef SYNTHESIS
  a_last_words: assert property (
    @(posedge clk) disable iff (rst)
    (bus.output_counter_load && bus.last_output_block &&
     !bus.output_counter_rst) |-> (bus.last_words_in != '0)
  );

  a_last_bytes: assert property (
    @(posedge clk) disable iff (rst)
    (bus.valid_bytes_enable && !bus.valid_bytes_reset) |-> w_bytes_ok
  );
`endif

endmodule

// File: tb/tb_shake_output_buffer.sv
// Scoreboard bench for shake_output_buffer: driver pushes expected words,
// a negedge monitor pops and compares against the DUT outputs.
module tb_shake_output_buffer;
  import shake_pkg::*;

  localparam int RATE_W = 1344;
  localparam int DATA_W = 64;
  localparam int WORDS = 21;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  shake_output_buffer_if #(.RATE_W(RATE_W), .DATA_W(DATA_W)) bus ();

  shake_output_buffer #(.RATE_W(RATE_W), .DATA_W(DATA_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t q[$];
  int total = 0;
  int bad = 0;

  task automatic check(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h @%0t", nm, got, exp, $time);
    end
  endtask

  // Monitor: consumes one expected word per accepted shift,
  // checks empty against the model and stability across quiet cycles.
  logic [63:0] p_d;
  logic [7:0]  p_k;
  logic        p_l;
  logic        p_e;
  bit          p_quiet = 1'b0;
  bit          m_ctl;
  bit          m_pop;
  exp_t        m_e;

  always @(negedge clk) begin
    m_ctl = rst || bus.output_buffer_we || bus.output_counter_load ||
            bus.output_counter_rst || bus.valid_bytes_enable ||
            bus.valid_bytes_reset;
    if (p_quiet) begin
      check("hold_data", bus.data_out, p_d);
      check("hold_keep", 64'(bus.keep_out), 64'(p_k));
      check("hold_last", 64'(bus.last_out), 64'(p_l));
      check("hold_empty", 64'(bus.output_buffer_empty), 64'(p_e));
    end
    m_pop = 1'b0;
    if (!m_ctl) begin
      check("empty", 64'(bus.output_buffer_empty), 64'(q.size() == 0));
      if (bus.output_buffer_shift_en && q.size() > 0) begin
        m_e = q.pop_front();
        m_pop = 1'b1;
        check("data", bus.data_out, m_e.d);
        check("keep", 64'(bus.keep_out), 64'(m_e.k));
        check("last", 64'(bus.last_out), 64'(m_e.l));
      end
    end
    p_quiet = !m_ctl && !m_pop;
    p_d = bus.data_out;
    p_k = bus.keep_out;
    p_l = bus.last_out;
    p_e = bus.output_buffer_empty;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_blk(input bit fin, input int rw, input int lw,
                          input int lb, input bit sh, input bit idx);
    logic [RATE_W-1:0] st;
    exp_t e;
    int n;
    for (int i = 0; i < WORDS; i++) begin
      st[i*64 +: 64] = idx ? 64'(i) : {$urandom, $urandom};
    end
    bus.state_in = st;
    bus.rate_words_in = 5'(rw);
    bus.last_words_in = 5'(lw);
    bus.last_bytes_in = 4'(lb);
    bus.last_output_block = fin;
    bus.output_buffer_we = 1'b1;
    bus.output_counter_load = 1'b1;
    bus.valid_bytes_enable = fin;
    bus.valid_bytes_reset = !fin;
    bus.output_buffer_shift_en = sh;
    n = fin ? lw : rw;
    if (n > WORDS) n = WORDS;
    q.delete();
    for (int i = 0; i < n; i++) begin
      e.d = st[i*64 +: 64];
      e.l = fin && (i == n - 1);
      e.k = e.l ? 8'((1 << lb) - 1) : 8'hFF;
      q.push_back(e);
    end
    tick();
    bus.output_buffer_we = 1'b0;
    bus.output_counter_load = 1'b0;
    bus.valid_bytes_enable = 1'b0;
    bus.valid_bytes_reset = 1'b0;
  endtask

  // mode 0: shift every cycle, 1: pattern 1,0,0, 2: random
  task automatic drain(input int mode, input int budget);
    int c = 0;
    while (q.size() > 0 && c < budget) begin
      case (mode)
        0: bus.output_buffer_shift_en = 1'b1;
        1: bus.output_buffer_shift_en = (c % 3 == 0);
        default: bus.output_buffer_shift_en = 1'($urandom_range(0, 1));
      endcase
      c++;
      tick();
    end
    bus.output_buffer_shift_en = 1'b0;
    check("drain_left", 64'(q.size()), 64'd0);
    tick();
  endtask

  task automatic shift_n(input int n);
    bus.output_buffer_shift_en = 1'b1;
    repeat (n) tick();
    bus.output_buffer_shift_en = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int rw, lw, fin;
    rst = 1'b1;
    bus.state_in = '0;
    bus.rate_words_in = '0;
    bus.last_words_in = 5'd1;
    bus.last_bytes_in = 4'd8;
    bus.output_buffer_we = 1'b0;
    bus.last_output_block = 1'b0;
    bus.output_counter_load = 1'b0;
    bus.output_counter_rst = 1'b0;
    bus.output_buffer_shift_en = 1'b0;
    bus.valid_bytes_enable = 1'b0;
    bus.valid_bytes_reset = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_empty", 64'(bus.output_buffer_empty), 64'd1);
    check("rst_data", bus.data_out, 64'd0);
    check("rst_keep", 64'(bus.keep_out), 64'hFF);
    check("rst_last", 64'(bus.last_out), 64'd0);
    @(posedge clk);
    #1;

    // SHAKE128 full block, lanes = index, shift held high
    load_blk(1'b0, 21, 21, 8, 1'b1, 1'b1);
    drain(0, 100);

    // shifts while empty: nothing moves, buffer fully drained to zero
    bus.output_buffer_shift_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("empty_shift_data", bus.data_out, 64'd0);
      check("empty_shift_empty", 64'(bus.output_buffer_empty), 64'd1);
      @(posedge clk);
      #1;
    end
    bus.output_buffer_shift_en = 1'b0;

    // SHAKE256 final block, 5 words, 3 bytes in last
    load_blk(1'b1, 17, 5, 3, 1'b0, 1'b0);
    drain(0, 100);

    // same with stalls
    load_blk(1'b1, 17, 5, 3, 1'b0, 1'b0);
    drain(1, 100);

    // reset mid-drain, then a clean full drain
    load_blk(1'b0, 17, 17, 8, 1'b0, 1'b0);
    shift_n(7);
    rst = 1'b1;
    q.delete();
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_empty", 64'(bus.output_buffer_empty), 64'd1);
    check("mid_rst_data", bus.data_out, 64'd0);
    check("mid_rst_last", 64'(bus.last_out), 64'd0);
    @(posedge clk);
    #1;
    load_blk(1'b0, 17, 17, 8, 1'b0, 1'b0);
    drain(0, 100);

    // reload with shift high while 3 words remain
    load_blk(1'b0, 17, 17, 8, 1'b0, 1'b0);
    shift_n(14);
    load_blk(1'b1, 17, $urandom_range(1, 17), $urandom_range(1, 8),
             1'b1, 1'b0);
    drain(0, 100);

    // random blocks, including oversize rates that saturate
    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) rw = $urandom_range(22, 31);
      else rw = $urandom_range(0, 1) ? 21 : 17;
      lw = $urandom_range(1, rw);
      fin = $urandom_range(0, 1);
      load_blk(1'(fin), rw, lw, $urandom_range(1, 8), 1'b0, 1'b0);
      drain($urandom_range(0, 2), 300);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
